// File: rtl/hazard_scoreboard_unit_if.sv
// Interface between the ID-stage hazard scoreboard and the pipeline it steers.
// The master side is the pipeline (issue/operand info, stage status); the
// slave side is the scoreboard unit producing pipeline-register modes.
interface hazard_scoreboard_unit_if #(
  parameter int GPR_NUM = 32,
  parameter int ADDR_W  = 5,
  parameter int CNT_W   = 32
);
  logic               issue_valid;
  logic               issue_rd_we;
  logic [ADDR_W-1:0]  issue_rd_addr;
  logic [3:0]         issue_lat;
  logic [ADDR_W-1:0]  id_rs1_addr;
  logic [ADDR_W-1:0]  id_rs2_addr;
  logic               id_rs1_re;
  logic               id_rs2_re;
  logic               id_early;
  logic               redirect;
  logic               exe_ready;
  logic               icache_miss;
  logic               dcache_miss;

  logic [1:0]         if_id_mode;
  logic [1:0]         id_exe_mode;
  logic [1:0]         exe_mem_mode;
  logic               if_stall;
  logic [GPR_NUM-1:0] sb_busy;
  logic [CNT_W-1:0]   stall_cnt;
  logic [CNT_W-1:0]   redirect_cnt;

  modport master (
    output issue_valid, issue_rd_we, issue_rd_addr, issue_lat,
    output id_rs1_addr, id_rs2_addr, id_rs1_re, id_rs2_re, id_early,
    output redirect, exe_ready, icache_miss, dcache_miss,
    input  if_id_mode, id_exe_mode, exe_mem_mode, if_stall,
    input  sb_busy, stall_cnt, redirect_cnt
  );

  modport slave (
    input  issue_valid, issue_rd_we, issue_rd_addr, issue_lat,
    input  id_rs1_addr, id_rs2_addr, id_rs1_re, id_rs2_re, id_early,
    input  redirect, exe_ready, icache_miss, dcache_miss,
    output if_id_mode, id_exe_mode, exe_mem_mode, if_stall,
    output sb_busy, stall_cnt, redirect_cnt
  );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// Per-GPR countdown scoreboard with fixed-priority stall/flush resolution.
// Each register holds the number of pipeline advances left until its pending
// result is forwardable to a normal consumer (value 1) or readable in ID by an
// early consumer (value 0). Modes are combinational; state updates on clk.
module hazard_scoreboard_unit #(
  parameter int GPR_NUM = 32,
  parameter int ADDR_W  = 5,
  parameter int MAX_LAT = 8,
  parameter int CNT_W   = 32
) (
  input logic                    clk,
  input logic                    rst,
  hazard_scoreboard_unit_if.slave sb_if
);

  localparam int         SB_W        = $clog2(MAX_LAT + 2);
  localparam logic [1:0] MODE_NORMAL = 2'b00;
  localparam logic [1:0] MODE_STALL  = 2'b01;
  localparam logic [1:0] MODE_FLUSH  = 2'b10;

  logic [SB_W-1:0]    sb_cnt [GPR_NUM];
  logic [SB_W-1:0]    issue_load;
  logic [SB_W-1:0]    rs1_cnt;
  logic [SB_W-1:0]    rs2_cnt;
  logic               rs1_hazard;
  logic               rs2_hazard;
  logic               operand_hazard;
  logic               issue_accept;
  logic               advance;
  logic               redirect_applied;
  logic [1:0]         if_id_mode;
  logic [1:0]         id_exe_mode;
  logic [1:0]         exe_mem_mode;
  logic               if_stall;
  logic [GPR_NUM-1:0] sb_busy;
  logic [CNT_W-1:0]   stall_cnt;
  logic [CNT_W-1:0]   redirect_cnt;

  // Clamp producer latency and convert it to the countdown start value.
  always_comb begin
    issue_load = '0;
    if (int'(sb_if.issue_lat) > MAX_LAT) begin
      issue_load = SB_W'(MAX_LAT + 1);
    end else begin
      issue_load = SB_W'(sb_if.issue_lat) + SB_W'(1);
    end
  end

  // Look up the pending countdown of both ID source registers (x0 reads 0).
  always_comb begin
    rs1_cnt = '0;
    rs2_cnt = '0;
    for (int r = 1; r < GPR_NUM; r++) begin
      if (sb_if.id_rs1_addr == ADDR_W'(r)) rs1_cnt = sb_cnt[r];
      if (sb_if.id_rs2_addr == ADDR_W'(r)) rs2_cnt = sb_cnt[r];
    end
  end

  // Early consumers need the value in ID, so they wait one extra advance.
  always_comb begin
    rs1_hazard = 1'b0;
    rs2_hazard = 1'b0;
    if (sb_if.id_rs1_re && (sb_if.id_rs1_addr != '0)) begin
      rs1_hazard = sb_if.id_early ? (rs1_cnt != '0) : (rs1_cnt > SB_W'(1));
    end
    if (sb_if.id_rs2_re && (sb_if.id_rs2_addr != '0)) begin
      rs2_hazard = sb_if.id_early ? (rs2_cnt != '0) : (rs2_cnt > SB_W'(1));
    end
    operand_hazard = rs1_hazard || rs2_hazard;
  end

  // Fixed-priority resolution of stall and flush sources into stage modes.
  always_comb begin
    if_id_mode       = MODE_NORMAL;
    id_exe_mode      = MODE_NORMAL;
    exe_mem_mode     = MODE_NORMAL;
    if_stall         = 1'b0;
    redirect_applied = 1'b0;
    if (rst) begin
      if_id_mode   = MODE_FLUSH;
      id_exe_mode  = MODE_FLUSH;
      exe_mem_mode = MODE_FLUSH;
    end else if (sb_if.dcache_miss) begin
      if_id_mode   = MODE_STALL;
      id_exe_mode  = MODE_STALL;
      exe_mem_mode = MODE_STALL;
      if_stall     = 1'b1;
    end else if (!sb_if.exe_ready) begin
      // EXE holds its instruction; MEM receives a bubble.
      if_id_mode   = MODE_STALL;
      id_exe_mode  = MODE_STALL;
      exe_mem_mode = MODE_FLUSH;
      if_stall     = 1'b1;
    end else if (operand_hazard) begin
      // A redirect here was computed from stale operands and is dropped.
      if_id_mode  = MODE_STALL;
      id_exe_mode = MODE_FLUSH;
      if_stall    = 1'b1;
    end else if (sb_if.redirect) begin
      if_id_mode       = MODE_FLUSH;
      redirect_applied = 1'b1;
    end else if (sb_if.icache_miss) begin
      if_id_mode = MODE_FLUSH;
      if_stall   = 1'b1;
    end
  end

  assign issue_accept = !rst && sb_if.issue_valid && sb_if.issue_rd_we &&
                        (sb_if.issue_rd_addr != '0) && (id_exe_mode == MODE_NORMAL);
  assign advance      = sb_if.exe_ready && !sb_if.dcache_miss;

  // Countdown per register: a new issue overrides the decrement on its rd.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < GPR_NUM; r++) sb_cnt[r] <= '0;
    end else begin
      for (int r = 0; r < GPR_NUM; r++) begin
        if ((r != 0) && issue_accept && (sb_if.issue_rd_addr == ADDR_W'(r))) begin
          sb_cnt[r] <= issue_load;
        end else if (advance && (sb_cnt[r] != '0)) begin
          sb_cnt[r] <= sb_cnt[r] - SB_W'(1);
        end
      end
    end
  end

  // Busy vector mirrors non-zero countdowns.
  always_comb begin
    sb_busy = '0;
    for (int r = 0; r < GPR_NUM; r++) sb_busy[r] = (sb_cnt[r] != '0);
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt    <= '0;
      redirect_cnt <= '0;
    end else begin
      if (if_stall && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (redirect_applied && (redirect_cnt != {CNT_W{1'b1}})) begin
        redirect_cnt <= redirect_cnt + CNT_W'(1);
      end
    end
  end

  assign sb_if.if_id_mode   = if_id_mode;
  assign sb_if.id_exe_mode  = id_exe_mode;
  assign sb_if.exe_mem_mode = exe_mem_mode;
  assign sb_if.if_stall     = if_stall;
  assign sb_if.sb_busy      = sb_busy;
  assign sb_if.stall_cnt    = stall_cnt;
  assign sb_if.redirect_cnt = redirect_cnt;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Scenario bench for hazard_scoreboard_unit: expected per-cycle modes are
// queued as stimulus is driven and popped when the outputs are sampled.
module tb_hazard_scoreboard_unit;

  typedef struct {
    logic       rst;
    logic       iv;
    logic       we;
    logic [4:0] rd;
    logic [3:0] lat;
    logic [4:0] rs1;
    logic       re1;
    logic [4:0] rs2;
    logic       re2;
    logic       early;
    logic       redir;
    logic       exe_rdy;
    logic       imiss;
    logic       dmiss;
  } stim_t;

  // {if_id, id_exe, exe_mem, if_stall}
  localparam logic [6:0] E_NORM = 7'b00_00_00_0;
  localparam logic [6:0] E_OPH  = 7'b01_10_00_1;
  localparam logic [6:0] E_DMS  = 7'b01_01_01_1;
  localparam logic [6:0] E_XNR  = 7'b01_01_10_1;
  localparam logic [6:0] E_RDR  = 7'b10_00_00_0;
  localparam logic [6:0] E_RST  = 7'b10_10_10_0;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  logic [6:0] exp_q [$];
  logic [6:0] cur_e;
  logic       cur_rst;
  int   exp_stall = 0;
  int   exp_redir = 0;

  hazard_scoreboard_unit_if #(.GPR_NUM(32), .ADDR_W(5), .CNT_W(32)) bus ();

  hazard_scoreboard_unit #(.GPR_NUM(32), .ADDR_W(5), .MAX_LAT(8), .CNT_W(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .sb_if (bus)
  );

  always #5 clk = ~clk;

  function automatic stim_t idle();
    stim_t s;
    s.rst = 0; s.iv = 0; s.we = 0; s.rd = 0; s.lat = 0;
    s.rs1 = 0; s.re1 = 0; s.rs2 = 0; s.re2 = 0; s.early = 0;
    s.redir = 0; s.exe_rdy = 1; s.imiss = 0; s.dmiss = 0;
    return s;
  endfunction

  function automatic stim_t ins(input logic we, input int rd, input int lat,
                                input int rs1, input logic re1, input int rs2,
                                input logic re2, input logic early);
    stim_t s = idle();
    s.iv = 1; s.we = we; s.rd = 5'(rd); s.lat = 4'(lat);
    s.rs1 = 5'(rs1); s.re1 = re1; s.rs2 = 5'(rs2); s.re2 = re2; s.early = early;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    rst                = s.rst;
    bus.issue_valid    = s.iv;
    bus.issue_rd_we    = s.we;
    bus.issue_rd_addr  = s.rd;
    bus.issue_lat      = s.lat;
    bus.id_rs1_addr    = s.rs1;
    bus.id_rs1_re      = s.re1;
    bus.id_rs2_addr    = s.rs2;
    bus.id_rs2_re      = s.re2;
    bus.id_early       = s.early;
    bus.redirect       = s.redir;
    bus.exe_ready      = s.exe_rdy;
    bus.icache_miss    = s.imiss;
    bus.dcache_miss    = s.dmiss;
    cur_rst            = s.rst;
  endtask

  // Drive one cycle of stimulus, queue its expectation, sample mid-cycle.
  task automatic step(input stim_t s, input logic [6:0] e);
    apply(s);
    cur_e = e;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Cross the active edge and account the cycle into the expected counters.
  task automatic adv();
    @(posedge clk);
    if (cur_rst) begin
      exp_stall = 0;
      exp_redir = 0;
    end else begin
      if (cur_e[0]) exp_stall++;
      if (cur_e == E_RDR) exp_redir++;
    end
    #1;
  endtask

  task automatic drain();
    apply(idle());
    cur_e = E_NORM;
    repeat (12) adv();
  endtask

  task automatic test_reset();
    stim_t st [3];
    logic [6:0] ex [3];
    logic [6:0] got, e;
    st[0] = ins(1, 2, 3, 0, 0, 0, 0, 0); st[0].rst = 1; ex[0] = E_RST;
    st[1] = st[0];                                    ex[1] = E_RST;
    st[2] = ins(0, 0, 0, 2, 1, 0, 0, 1);              ex[2] = E_NORM;
    for (int i = 0; i < 3; i++) begin
      step(st[i], ex[i]);
      got = {bus.if_id_mode, bus.id_exe_mode, bus.exe_mem_mode, bus.if_stall};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL reset step %0d: got %b want %b", i, got, e);
      end
      adv();
      if (i == 1) begin
        checks++;
        if (bus.sb_busy !== 32'h0 || bus.stall_cnt !== 32'd0 || bus.redirect_cnt !== 32'd0) begin
          failures++;
          $display("FAIL reset_state: busy=%h stall=%0d redir=%0d want 0/0/0",
                   bus.sb_busy, bus.stall_cnt, bus.redirect_cnt);
        end
      end
    end
  endtask

  task automatic test_load_use();
    stim_t st [4];
    logic [6:0] ex [4];
    logic [6:0] got, e;
    st[0] = ins(1, 5, 1, 0, 0, 0, 0, 0); ex[0] = E_NORM;
    st[1] = ins(1, 6, 0, 5, 1, 1, 1, 0); ex[1] = E_OPH;
    st[2] = st[1];                        ex[2] = E_NORM;
    st[3] = idle();                       ex[3] = E_NORM;
    for (int i = 0; i < 4; i++) begin
      step(st[i], ex[i]);
      if (i == 1) begin
        checks++;
        if (bus.sb_busy[5] !== 1'b1) begin
          failures++;
          $display("FAIL load_busy_x5: got %b want 1", bus.sb_busy[5]);
        end
      end
      got = {bus.if_id_mode, bus.id_exe_mode, bus.exe_mem_mode, bus.if_stall};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL load_use step %0d: got %b want %b", i, got, e);
      end
      adv();
    end
    checks++;
    if (bus.stall_cnt !== 32'(exp_stall) || exp_stall != 1) begin
      failures++;
      $display("FAIL load_use_stall_cnt: got %0d want 1 (tally %0d)", bus.stall_cnt, exp_stall);
    end
  endtask

  task automatic test_early();
    stim_t st [7];
    logic [6:0] ex [7];
    logic [6:0] got, e;
    st[0] = ins(1, 7, 0, 0, 0, 0, 0, 0); ex[0] = E_NORM;
    st[1] = ins(0, 0, 0, 7, 1, 0, 1, 1); ex[1] = E_OPH;
    st[2] = st[1];                        ex[2] = E_NORM;
    st[3] = ins(1, 7, 1, 0, 0, 0, 0, 0); ex[3] = E_NORM;
    st[4] = st[1];                        ex[4] = E_OPH;
    st[5] = st[1]; st[5].redir = 1;       ex[5] = E_OPH;
    st[6] = st[1];                        ex[6] = E_NORM;
    for (int i = 0; i < 7; i++) begin
      step(st[i], ex[i]);
      got = {bus.if_id_mode, bus.id_exe_mode, bus.exe_mem_mode, bus.if_stall};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL early step %0d: got %b want %b", i, got, e);
      end
      adv();
    end
    checks++;
    if (bus.redirect_cnt !== 32'd0) begin
      failures++;
      $display("FAIL early_redirect_dropped: redirect_cnt=%0d want 0", bus.redirect_cnt);
    end
  endtask

  task automatic test_mul();
    stim_t st [15];
    logic [6:0] ex [15];
    logic [6:0] got, e;
    int base;
    st[0] = ins(1, 9, 4, 0, 0, 0, 0, 0); ex[0] = E_NORM;
    for (int i = 1; i <= 4; i++) begin st[i] = ins(1, 10, 0, 9, 1, 0, 0, 0); ex[i] = E_OPH; end
    st[5] = st[1];                        ex[5] = E_NORM;
    st[6] = ins(1, 9, 4, 0, 0, 0, 0, 0); ex[6] = E_NORM;
    for (int i = 7; i <= 13; i++) begin st[i] = ins(1, 10, 0, 9, 1, 0, 0, 0); ex[i] = E_OPH; end
    for (int i = 9; i <= 11; i++) begin st[i].dmiss = 1; ex[i] = E_DMS; end
    st[14] = st[7];                       ex[14] = E_NORM;
    base = exp_stall;
    for (int i = 0; i < 15; i++) begin
      step(st[i], ex[i]);
      got = {bus.if_id_mode, bus.id_exe_mode, bus.exe_mem_mode, bus.if_stall};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL mul step %0d: got %b want %b", i, got, e);
      end
      adv();
    end
    checks++;
    if (bus.stall_cnt !== 32'(exp_stall) || (exp_stall - base) != 11) begin
      failures++;
      $display("FAIL mul_stall_cnt: got %0d want %0d", bus.stall_cnt, base + 11);
    end
  endtask

  task automatic test_lat_sat();
    stim_t st [10];
    logic [6:0] ex [10];
    logic [6:0] got, e;
    st[0] = ins(1, 11, 15, 0, 0, 0, 0, 0); ex[0] = E_NORM;
    for (int i = 1; i <= 8; i++) begin st[i] = ins(0, 0, 0, 0, 0, 11, 1, 0); ex[i] = E_OPH; end
    st[9] = st[1];                          ex[9] = E_NORM;
    for (int i = 0; i < 10; i++) begin
      step(st[i], ex[i]);
      got = {bus.if_id_mode, bus.id_exe_mode, bus.exe_mem_mode, bus.if_stall};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL lat_sat step %0d: got %b want %b", i, got, e);
      end
      adv();
    end
  endtask

  task automatic test_x0();
    stim_t st [3];
    logic [6:0] ex [3];
    logic [6:0] got, e;
    st[0] = ins(1, 0, 5, 0, 0, 0, 0, 0); ex[0] = E_NORM;
    st[1] = ins(0, 0, 0, 0, 1, 0, 1, 1); ex[1] = E_NORM;
    st[2] = ins(0, 0, 0, 0, 1, 0, 1, 0); ex[2] = E_NORM;
    for (int i = 0; i < 3; i++) begin
      step(st[i], ex[i]);
      got = {bus.if_id_mode, bus.id_exe_mode, bus.exe_mem_mode, bus.if_stall};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL x0 step %0d: got %b want %b", i, got, e);
      end
      checks++;
      if (i > 0 && bus.sb_busy !== 32'h0) begin
        failures++;
        $display("FAIL x0_busy: got %h want 0", bus.sb_busy);
      end
      adv();
    end
  endtask

  task automatic test_exe_not_ready();
    stim_t st [4];
    logic [6:0] ex [4];
    logic [6:0] got, e;
    st[0] = idle(); st[0].exe_rdy = 0; st[0].redir = 1; st[0].imiss = 1; ex[0] = E_XNR;
    st[1] = st[0];                                                        ex[1] = E_XNR;
    st[2] = idle(); st[2].redir = 1; st[2].imiss = 1;                     ex[2] = E_RDR;
    st[3] = idle();                                                       ex[3] = E_NORM;
    for (int i = 0; i < 4; i++) begin
      step(st[i], ex[i]);
      got = {bus.if_id_mode, bus.id_exe_mode, bus.exe_mem_mode, bus.if_stall};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL exe_not_ready step %0d: got %b want %b", i, got, e);
      end
      adv();
      if (i == 1) begin
        checks++;
        if (bus.redirect_cnt !== 32'd0) begin
          failures++;
          $display("FAIL xnr_redirect_hold: got %0d want 0", bus.redirect_cnt);
        end
      end
    end
    checks++;
    if (bus.redirect_cnt !== 32'd1 || bus.stall_cnt !== 32'(exp_stall)) begin
      failures++;
      $display("FAIL xnr_counters: redirect=%0d want 1 stall=%0d want %0d",
               bus.redirect_cnt, bus.stall_cnt, exp_stall);
    end
  endtask

  task automatic test_reset_mid();
    stim_t st [5];
    logic [6:0] ex [5];
    logic [6:0] got, e;
    st[0] = ins(1, 3, 6, 0, 0, 0, 0, 0);          ex[0] = E_NORM;
    st[1] = idle();                               ex[1] = E_NORM;
    st[2] = ins(1, 4, 3, 0, 0, 0, 0, 0); st[2].rst = 1; ex[2] = E_RST;
    st[3] = ins(1, 12, 0, 3, 1, 4, 1, 1);          ex[3] = E_NORM;
    st[4] = idle();                               ex[4] = E_NORM;
    for (int i = 0; i < 5; i++) begin
      step(st[i], ex[i]);
      if (i == 1) begin
        checks++;
        if (bus.sb_busy[3] !== 1'b1) begin
          failures++;
          $display("FAIL mid_busy_x3: got %b want 1", bus.sb_busy[3]);
        end
      end
      got = {bus.if_id_mode, bus.id_exe_mode, bus.exe_mem_mode, bus.if_stall};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL reset_mid step %0d: got %b want %b", i, got, e);
      end
      adv();
      if (i == 2) begin
        checks++;
        if (bus.sb_busy !== 32'h0 || bus.stall_cnt !== 32'd0 || bus.redirect_cnt !== 32'd0) begin
          failures++;
          $display("FAIL reset_mid_state: busy=%h stall=%0d redir=%0d want 0/0/0",
                   bus.sb_busy, bus.stall_cnt, bus.redirect_cnt);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    drain();
    test_early();
    drain();
    test_mul();
    drain();
    test_lat_sat();
    drain();
    test_x0();
    drain();
    test_exe_not_ready();
    drain();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, want completion");
    $fatal(1);
  end

endmodule
